// File: rtl/store_buffer.sv
// Posted-store buffer ahead of a single-port data memory: stores queue in an
// in-order FIFO and drain whenever no load is using the port; loads forward from it.
module store_buffer #(
  parameter int WIDTH         = 32,
  parameter int LOG_DEPTH_MEM = 8,
  parameter int SB_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_load,
  input  logic                       pipe_store,
  input  logic [LOG_DEPTH_MEM-1:0]   pipe_addr,
  input  logic [WIDTH-1:0]           pipe_wdata,
  output logic [WIDTH-1:0]           pipe_rdata,
  output logic                       pipe_stall,
  input  logic                       sync_req,
  output logic                       sync_done,
  output logic [$clog2(SB_DEPTH):0]  sb_count,
  output logic [LOG_DEPTH_MEM-1:0]   dataAddress,
  output logic [WIDTH-1:0]           writeMemData,
  output logic                       memRead,
  output logic                       memWrite,
  input  logic [WIDTH-1:0]           readMemData
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LOG_DEPTH_MEM-1:0] addr_q [SB_DEPTH];
  logic [WIDTH-1:0]         data_q [SB_DEPTH];
  logic [SB_DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic             full, empty;
  logic             hit;
  logic [WIDTH-1:0] hit_data;
  logic             accept, mem_read, drain;

  assign full  = (count_q == CNT_W'(SB_DEPTH));
  assign empty = (count_q == '0);

  // Scan from head towards tail so the youngest matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == pipe_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  // Store handshake: the pipeline holds pipe_store/pipe_addr/pipe_wdata while
  // pipe_stall=1; the store transfers on a rising edge with pipe_store=1, pipe_stall=0.
  // A load may share the cycle with a store; its miss is what keeps the port busy.
  assign accept   = pipe_store && !full && !sync_req;
  assign mem_read = pipe_load && !hit;
  assign drain    = !empty && !mem_read;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (drain) begin
      head_d          = head_q + PTR_W'(1);
      valid_d[head_q] = 1'b0;
    end
    if (accept) begin
      tail_d          = tail_q + PTR_W'(1);
      valid_d[tail_q] = 1'b1;
    end
    if (accept && !drain) begin
      count_d = count_q + CNT_W'(1);
    end else if (drain && !accept) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset: valid_q alone decides whether an entry is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[tail_q] <= pipe_addr;
      data_q[tail_q] <= pipe_wdata;
    end
  end

  always_comb begin
    pipe_rdata = '0;
    if (pipe_load) begin
      pipe_rdata = hit ? hit_data : readMemData;
    end
  end

  always_comb begin
    dataAddress  = '0;
    writeMemData = '0;
    if (mem_read) begin
      dataAddress = pipe_addr;
    end else if (drain) begin
      dataAddress  = addr_q[head_q];
      writeMemData = data_q[head_q];
    end
  end

  assign memRead    = mem_read;
  assign memWrite   = drain;
  assign pipe_stall = pipe_store && !accept;
  assign sync_done  = sync_req && empty;
  assign sb_count   = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: behavioural data memory, write log for
// drain-order checking, one task per scenario.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        pipe_load, pipe_store, sync_req;
  logic [7:0]  pipe_addr;
  logic [31:0] pipe_wdata;
  logic [31:0] pipe_rdata;
  logic        pipe_stall, sync_done;
  logic [2:0]  sb_count;
  logic [7:0]  dataAddress;
  logic [31:0] writeMemData;
  logic        memRead, memWrite;
  wire  [31:0] readMemData;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [256];
  logic        written [256];
  logic [39:0] wr_q [$];
  logic [39:0] exp_q [$];

  store_buffer #(.WIDTH(32), .LOG_DEPTH_MEM(8), .SB_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_load(pipe_load), .pipe_store(pipe_store), .pipe_addr(pipe_addr),
    .pipe_wdata(pipe_wdata), .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
    .sync_req(sync_req), .sync_done(sync_done), .sb_count(sb_count),
    .dataAddress(dataAddress), .writeMemData(writeMemData),
    .memRead(memRead), .memWrite(memWrite), .readMemData(readMemData)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h20) ? 32'h0000_005A : (32'hC0DE_0000 | {24'h0, a});
  endfunction

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return (written[a] === 1'b1) ? mem[a] : init_val(a);
  endfunction

  assign readMemData = memRead ? mem_word(dataAddress) : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (memWrite === 1'b1) begin
      mem[dataAddress]     <= writeMemData;
      written[dataAddress] <= 1'b1;
      wr_q.push_back({dataAddress, writeMemData});
    end
  end

  // driver: apply one cycle of inputs at the falling edge, settle 1 time unit
  task automatic drive(input logic ld, input logic st, input logic [7:0] a,
                       input logic [31:0] d, input logic sr);
    @(negedge clk);
    pipe_load  = ld;
    pipe_store = st;
    pipe_addr  = a;
    pipe_wdata = d;
    sync_req   = sr;
    #1;
  endtask

  task automatic test_reset();
    int n_wr;
    @(negedge clk); #1;
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL rst_stall act=%0h exp=0", pipe_stall); end
    checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL rst_sync_done act=%0h exp=0", sync_done); end
    checks++; if (memRead !== 1'b0) begin errors++; $display("FAIL rst_memRead act=%0h exp=0", memRead); end
    checks++; if (memWrite !== 1'b0) begin errors++; $display("FAIL rst_memWrite act=%0h exp=0", memWrite); end
    checks++; if (dataAddress !== 8'h00) begin errors++; $display("FAIL rst_addr act=%0h exp=0", dataAddress); end
    checks++; if (writeMemData !== 32'h0) begin errors++; $display("FAIL rst_wdata act=%0h exp=0", writeMemData); end
    checks++; if (pipe_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata act=%0h exp=0", pipe_rdata); end
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL rst_count act=%0d exp=0", sb_count); end
    rst = 1'b0;
    // queue three stores, each paired with a missing load so nothing drains
    drive(1, 1, 8'h30, 32'hAAAA_0030, 0);
    checks++; if (pipe_rdata !== 32'hC0DE_0030) begin errors++; $display("FAIL rst_fill_rdata act=%0h exp=c0de0030", pipe_rdata); end
    drive(1, 1, 8'h31, 32'hAAAA_0031, 0);
    drive(1, 1, 8'h32, 32'hAAAA_0032, 0);
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL rst_fill_stall act=%0h exp=0", pipe_stall); end
    drive(0, 0, 8'h00, 32'h0, 0);
    checks++; if (sb_count !== 3'd3) begin errors++; $display("FAIL rst_fill_count act=%0d exp=3", sb_count); end
    checks++; if (memWrite !== 1'b1) begin errors++; $display("FAIL rst_pre_drain act=%0h exp=1", memWrite); end
    n_wr = wr_q.size();
    #2 rst = 1'b1;
    #1;
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL rst_async_count act=%0d exp=0", sb_count); end
    checks++; if (memWrite !== 1'b0) begin errors++; $display("FAIL rst_async_memWrite act=%0h exp=0", memWrite); end
    checks++; if (dataAddress !== 8'h00) begin errors++; $display("FAIL rst_async_addr act=%0h exp=0", dataAddress); end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 8'h00, 32'h0, 0);
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL rst_after_count act=%0d exp=0", sb_count); end
    checks++; if (wr_q.size() !== n_wr) begin errors++; $display("FAIL rst_no_write act=%0d exp=%0d", wr_q.size(), n_wr); end
    checks++; if (mem_word(8'h30) !== 32'hC0DE_0030) begin errors++; $display("FAIL rst_mem30 act=%0h exp=c0de0030", mem_word(8'h30)); end
    checks++; if (mem_word(8'h32) !== 32'hC0DE_0032) begin errors++; $display("FAIL rst_mem32 act=%0h exp=c0de0032", mem_word(8'h32)); end
  endtask

  task automatic test_post_drain();
    drive(0, 1, 8'h04, 32'h1111_1111, 0);
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL pd_stall act=%0h exp=0", pipe_stall); end
    checks++; if (memWrite !== 1'b0) begin errors++; $display("FAIL pd_empty_write act=%0h exp=0", memWrite); end
    drive(0, 0, 8'h00, 32'h0, 0);
    checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL pd_count1 act=%0d exp=1", sb_count); end
    checks++; if (memWrite !== 1'b1) begin errors++; $display("FAIL pd_memWrite act=%0h exp=1", memWrite); end
    checks++; if (dataAddress !== 8'h04) begin errors++; $display("FAIL pd_addr act=%0h exp=04", dataAddress); end
    checks++; if (writeMemData !== 32'h1111_1111) begin errors++; $display("FAIL pd_wdata act=%0h exp=11111111", writeMemData); end
    checks++; if (memRead !== 1'b0) begin errors++; $display("FAIL pd_memRead act=%0h exp=0", memRead); end
    drive(0, 0, 8'h00, 32'h0, 0);
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL pd_count0 act=%0d exp=0", sb_count); end
    checks++; if (memWrite !== 1'b0) begin errors++; $display("FAIL pd_idle_write act=%0h exp=0", memWrite); end
    checks++; if (mem_word(8'h04) !== 32'h1111_1111) begin errors++; $display("FAIL pd_mem04 act=%0h exp=11111111", mem_word(8'h04)); end
  endtask

  task automatic test_forwarding();
    drive(1, 1, 8'h11, 32'h0000_0F11, 0);
    checks++; if (pipe_rdata !== 32'hC0DE_0011) begin errors++; $display("FAIL fw_miss_rdata act=%0h exp=c0de0011", pipe_rdata); end
    drive(1, 1, 8'h10, 32'h0000_000A, 0);
    checks++; if (memRead !== 1'b1) begin errors++; $display("FAIL fw_miss_memRead act=%0h exp=1", memRead); end
    // lone store: head (0x11) drains while 0xB joins behind 0xA
    drive(0, 1, 8'h10, 32'h0000_000B, 0);
    checks++; if (dataAddress !== 8'h11) begin errors++; $display("FAIL fw_drain_addr act=%0h exp=11", dataAddress); end
    drive(1, 0, 8'h10, 32'h0, 0);
    checks++; if (sb_count !== 3'd2) begin errors++; $display("FAIL fw_count act=%0d exp=2", sb_count); end
    checks++; if (pipe_rdata !== 32'h0000_000B) begin errors++; $display("FAIL fw_youngest act=%0h exp=b", pipe_rdata); end
    checks++; if (memRead !== 1'b0) begin errors++; $display("FAIL fw_hit_memRead act=%0h exp=0", memRead); end
    checks++; if (memWrite !== 1'b1) begin errors++; $display("FAIL fw_hit_drain act=%0h exp=1", memWrite); end
    checks++; if (writeMemData !== 32'h0000_000A) begin errors++; $display("FAIL fw_drain_old act=%0h exp=a", writeMemData); end
    drive(1, 0, 8'h10, 32'h0, 0);
    checks++; if (pipe_rdata !== 32'h0000_000B) begin errors++; $display("FAIL fw_hit2 act=%0h exp=b", pipe_rdata); end
    checks++; if (writeMemData !== 32'h0000_000B) begin errors++; $display("FAIL fw_drain_new act=%0h exp=b", writeMemData); end
    drive(1, 0, 8'h10, 32'h0, 0);
    checks++; if (memRead !== 1'b1) begin errors++; $display("FAIL fw_mem_memRead act=%0h exp=1", memRead); end
    checks++; if (pipe_rdata !== 32'h0000_000B) begin errors++; $display("FAIL fw_mem_rdata act=%0h exp=b", pipe_rdata); end
    drive(0, 0, 8'h10, 32'h0, 0);
    checks++; if (pipe_rdata !== 32'h0) begin errors++; $display("FAIL fw_noload_rdata act=%0h exp=0", pipe_rdata); end
  endtask

  task automatic test_load_priority();
    drive(1, 1, 8'h40, 32'h0000_00D0, 0);
    drive(1, 1, 8'h41, 32'h0000_00D1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'h20, 32'h0, 0);
      checks++; if (pipe_rdata !== 32'h0000_005A) begin errors++; $display("FAIL lp_rdata%0d act=%0h exp=5a", i, pipe_rdata); end
      checks++; if (memWrite !== 1'b0 || memRead !== 1'b1) begin errors++; $display("FAIL lp_port%0d act=r%0h/w%0h exp=r1/w0", i, memRead, memWrite); end
      checks++; if (sb_count !== 3'd2) begin errors++; $display("FAIL lp_count%0d act=%0d exp=2", i, sb_count); end
    end
    drive(0, 0, 8'h00, 32'h0, 0);
    checks++; if (memWrite !== 1'b1 || dataAddress !== 8'h40 || writeMemData !== 32'hD0) begin errors++; $display("FAIL lp_resume0 act=w%0h@%0h=%0h exp=w1@40=d0", memWrite, dataAddress, writeMemData); end
    drive(0, 0, 8'h00, 32'h0, 0);
    checks++; if (memWrite !== 1'b1 || dataAddress !== 8'h41 || writeMemData !== 32'hD1) begin errors++; $display("FAIL lp_resume1 act=w%0h@%0h=%0h exp=w1@41=d1", memWrite, dataAddress, writeMemData); end
    drive(0, 0, 8'h00, 32'h0, 0);
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL lp_empty act=%0d exp=0", sb_count); end
  endtask

  task automatic test_full_wrap();
    int n_wr;
    logic [7:0]  a;
    logic [31:0] d;
    n_wr = wr_q.size();
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      a = 8'h50 + 8'(k);
      d = 32'h5000_0000 + 32'(k);
      drive(1, 1, a, d, 0);
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL fw_fill_stall%0d act=%0h exp=0", k, pipe_stall); end
      exp_q.push_back({a, d});
    end
    drive(1, 1, 8'h54, 32'h5000_0004, 0);
    checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL full_stall act=%0h exp=1", pipe_stall); end
    checks++; if (sb_count !== 3'd4) begin errors++; $display("FAIL full_count act=%0d exp=4", sb_count); end
    drive(0, 1, 8'h54, 32'h5000_0004, 0);
    checks++; if (pipe_stall !== 1'b1 || memWrite !== 1'b1) begin errors++; $display("FAIL full_drain_stall act=s%0h/w%0h exp=s1/w1", pipe_stall, memWrite); end
    for (int k = 4; k < 13; k++) begin
      a = 8'h50 + 8'(k);
      d = 32'h5000_0000 + 32'(k);
      drive(0, 1, a, d, 0);
      checks++; if (pipe_stall !== 1'b0 || sb_count !== 3'd3) begin errors++; $display("FAIL wrap_accept%0d act=s%0h/c%0d exp=s0/c3", k, pipe_stall, sb_count); end
      exp_q.push_back({a, d});
    end
    for (int k = 0; k < 4; k++) drive(0, 0, 8'h00, 32'h0, 0);
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL wrap_empty act=%0d exp=0", sb_count); end
    checks++; if (wr_q.size() - n_wr !== exp_q.size()) begin errors++; $display("FAIL wrap_nwrites act=%0d exp=%0d", wr_q.size() - n_wr, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && n_wr + i < wr_q.size(); i++) begin
      checks++; if (wr_q[n_wr + i] !== exp_q[i]) begin errors++; $display("FAIL wrap_order%0d act=%0h exp=%0h", i, wr_q[n_wr + i], exp_q[i]); end
    end
  endtask

  task automatic test_sync();
    for (int k = 0; k < 3; k++) drive(1, 1, 8'h60 + 8'(k), 32'h6000_0000 + 32'(k), 0);
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 8'h70, 32'h7070_7070, 1);
      checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL sync_stall%0d act=%0h exp=1", c, pipe_stall); end
      checks++; if (sync_done !== 1'b0) begin errors++; $display("FAIL sync_early%0d act=%0h exp=0", c, sync_done); end
      checks++; if (sb_count !== 3'(3 - c) || memWrite !== 1'b1) begin errors++; $display("FAIL sync_drain%0d act=c%0d/w%0h exp=c%0d/w1", c, sb_count, memWrite, 3 - c); end
    end
    drive(0, 1, 8'h70, 32'h7070_7070, 1);
    checks++; if (sync_done !== 1'b1) begin errors++; $display("FAIL sync_done act=%0h exp=1", sync_done); end
    checks++; if (pipe_stall !== 1'b1 || memWrite !== 1'b0) begin errors++; $display("FAIL sync_done_port act=s%0h/w%0h exp=s1/w0", pipe_stall, memWrite); end
    drive(0, 1, 8'h70, 32'h7070_7070, 0);
    checks++; if (sync_done !== 1'b0 || pipe_stall !== 1'b0) begin errors++; $display("FAIL sync_release act=d%0h/s%0h exp=d0/s0", sync_done, pipe_stall); end
    drive(0, 0, 8'h00, 32'h0, 0);
    checks++; if (sb_count !== 3'd1 || dataAddress !== 8'h70 || writeMemData !== 32'h7070_7070) begin errors++; $display("FAIL sync_post act=c%0d@%0h=%0h exp=c1@70=70707070", sb_count, dataAddress, writeMemData); end
    drive(0, 0, 8'h00, 32'h0, 0);
    checks++; if (mem_word(8'h62) !== 32'h6000_0002) begin errors++; $display("FAIL sync_mem62 act=%0h exp=60000002", mem_word(8'h62)); end
  endtask

  initial begin
    rst        = 1'b1;
    pipe_load  = 1'b0;
    pipe_store = 1'b0;
    pipe_addr  = 8'h00;
    pipe_wdata = 32'h0;
    sync_req   = 1'b0;
    test_reset();
    test_post_drain();
    test_forwarding();
    test_load_priority();
    test_full_wrap();
    test_sync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
